// File: rtl/alu_stream_issue.sv
// Command/result streaming stage around the external slice ALU: registers accepted
// commands onto the ALU operand ports and queues RESULT/CMP in an in-order output FIFO.
module alu_stream_issue #(
   parameter int unsigned S     = 4,
   parameter int unsigned N_A   = 2,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   input  logic [2*S*N_A+2:0]   s_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic [S*N_A+1:0]     m_axis_tdata,
   output logic [3:0]           m_axis_tuser,
   output logic [S*N_A-1:0]     alu_a,
   output logic [S*N_A-1:0]     alu_b,
   output logic [2:0]           alu_op,
   input  logic [S*N_A-1:0]     alu_result,
   input  logic [1:0]           alu_cmp,
   output logic [CNT_W-1:0]     done_cnt
);

   localparam int unsigned W     = S * N_A;
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = $clog2(DEPTH + 1) + 1;
   localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

   typedef struct packed {
      logic [1:0]   cmp;
      logic [W-1:0] result;
      logic         err;
      logic [2:0]   op;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           push_entry;
   entry_t           head;

   logic [PTR_W-1:0] wptr, wptr_nx;
   logic [PTR_W-1:0] rptr, rptr_nx;
   logic [OCC_W-1:0] count, count_nx;
   logic             issue_v, issue_v_nx;
   logic [W-1:0]     alu_a_nx, alu_b_nx;
   logic [2:0]       alu_op_nx;
   logic [CNT_W-1:0] done_cnt_nx;

   logic             issue_hs;
   logic             push;
   logic             pop;

   // Issue gating reserves a FIFO slot for the result still in the ALU stage.
   assign s_axis_tready = aresetn & ((count + OCC_W'(issue_v)) < DEPTH_OCC);
   assign issue_hs      = s_axis_tvalid & s_axis_tready;
   assign push          = issue_v;
   assign m_axis_tvalid = (count != '0);
   assign pop           = m_axis_tvalid & m_axis_tready;
   assign head          = mem[rptr];

   // Reserved opcodes (op[2]=1) report a fixed RESULT=0 / CMP=11 signature.
   always_comb begin
      push_entry.op     = alu_op;
      push_entry.err    = alu_op[2];
      push_entry.result = alu_result;
      push_entry.cmp    = alu_cmp;
      if (alu_op[2]) begin
         push_entry.result = '0;
         push_entry.cmp    = 2'b11;
      end
   end

   // Output reads zero whenever nothing is queued, so stale entries never show.
   always_comb begin
      m_axis_tdata = '0;
      m_axis_tuser = '0;
      if (m_axis_tvalid) begin
         m_axis_tdata = {head.cmp, head.result};
         m_axis_tuser = {head.err, head.op};
      end
   end

   always_comb begin
      alu_a_nx    = alu_a;
      alu_b_nx    = alu_b;
      alu_op_nx   = alu_op;
      issue_v_nx  = 1'b0;
      wptr_nx     = wptr;
      rptr_nx     = rptr;
      count_nx    = count;
      done_cnt_nx = done_cnt;

      if (issue_hs) begin
         alu_a_nx   = s_axis_tdata[W-1:0];
         alu_b_nx   = s_axis_tdata[2*W-1:W];
         alu_op_nx  = s_axis_tdata[2*W+2:2*W];
         issue_v_nx = 1'b1;
      end

      if (push) begin
         wptr_nx = wptr + PTR_W'(1);
      end

      if (pop) begin
         rptr_nx     = rptr + PTR_W'(1);
         done_cnt_nx = done_cnt + CNT_W'(1);
      end

      case ({push, pop})
         2'b10:   count_nx = count + OCC_W'(1);
         2'b01:   count_nx = count - OCC_W'(1);
         default: count_nx = count;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         alu_a    <= '0;
         alu_b    <= '0;
         alu_op   <= '0;
         issue_v  <= 1'b0;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         done_cnt <= '0;
      end else begin
         alu_a    <= alu_a_nx;
         alu_b    <= alu_b_nx;
         alu_op   <= alu_op_nx;
         issue_v  <= issue_v_nx;
         wptr     <= wptr_nx;
         rptr     <= rptr_nx;
         count    <= count_nx;
         done_cnt <= done_cnt_nx;
      end
   end

   // Storage needs no reset: pointers and count define which entries are live.
   always_ff @(posedge aclk) begin
      if (push) begin
         mem[wptr] <= push_entry;
      end
   end

endmodule
